hazard_unit_mc: RTL and testbench

- Parametrised successor to the 5-stage pipeline hazard unit. Sits beside the F/D/E/M/W pipeline registers and drives their stall and flush enables.
- Keeps M/W operand forwarding and branch flushing.
- Adds a configurable-length load-use stall (multi-cycle data memory) and a handshake-driven hold for a multi-cycle execute unit (mul/div), with a watchdog.
- Adds saturating stall and flush performance counters.

---
 rtl/hazard_unit_mc.sv | 167 ++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - pipeline hazard unit with forwarding, load-use and multi-cycle stalls
// Drives F/D/E/M stall/flush enables and keeps saturating stall/flush counters.
module hazard_unit_mc #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              McOpE,
    input  logic              McDoneE,
    input  logic              ClrCnt,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              McTimeout,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);
    localparam int MCW = $clog2(MC_TIMEOUT + 1);
    localparam logic [MCW-1:0] MC_MAX  = MCW'(MC_TIMEOUT);
    localparam logic [MCW-1:0] MC_WARN = MCW'(MC_TIMEOUT - 1);
    localparam logic [3:0]     LD_INIT = 4'(LOAD_STALL - 1);

    typedef enum logic [1:0] {IDLE, LDSTALL, MCBUSY} state_t;

    state_t         state;
    logic [3:0]     ldCnt;
    logic [MCW-1:0] mcCnt;
    logic           lw;
    logic           branchTaken;

    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs);
        if (rs != '0 && rs == RdM && RegWriteM)
            return 2'b10;
        else if (rs != '0 && rs == RdW && RegWriteW)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        ForwardAE = fwdSel(Rs1E);
        ForwardBE = fwdSel(Rs2E);
    end

    assign lw = ResultSrcE0 && (RdE != '0) && (RdE == Rs1D || RdE == Rs2D);

    // Stall/flush enables are gated by rst_n so they fall as soon as reset asserts.
    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        branchTaken = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (PCSrcE) begin
                        FlushD      = 1'b1;
                        FlushE      = 1'b1;
                        branchTaken = 1'b1;
                    end else if (lw) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end else if (McOpE && !McDoneE) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end
                end
                LDSTALL: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
                MCBUSY: begin
                    if (!McDoneE) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ldCnt     <= '0;
            mcCnt     <= '0;
            McTimeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The IDLE cycle is the first bubble; LDSTALL supplies the rest.
                    if (!PCSrcE && lw) begin
                        if (LOAD_STALL > 1) begin
                            state <= LDSTALL;
                            ldCnt <= LD_INIT;
                        end
                    end else if (!PCSrcE && McOpE && !McDoneE) begin
                        state <= MCBUSY;
                        mcCnt <= MCW'(1);
                    end
                end
                LDSTALL: begin
                    if (ldCnt <= 4'd1)
                        state <= IDLE;
                    else
                        ldCnt <= ldCnt - 4'd1;
                end
                MCBUSY: begin
                    if (McDoneE) begin
                        state <= IDLE;
                        mcCnt <= '0;
                    end else begin
                        if (mcCnt != MC_MAX)
                            mcCnt <= mcCnt + 1'b1;
                        if (mcCnt == MC_WARN)
                            McTimeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else if (ClrCnt) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF && StallCnt != '1)
                StallCnt <= StallCnt + 1'b1;
            if (branchTaken && FlushCnt != '1)
                FlushCnt <= FlushCnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - scoreboard testbench for hazard_unit_mc
module tb_hazard_unit_mc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McOpE, McDoneE, ClrCnt;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McTimeout;
    logic [3:0] StallCnt, FlushCnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [5:0] ctlQ[$];
    logic [3:0] fwdQ[$];

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LD   = 6'b110010;
    localparam logic [5:0] C_MC   = 6'b111001;
    localparam logic [5:0] C_BR   = 6'b000110;

    wire [5:0] ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};
    wire [3:0] fwd = {ForwardAE, ForwardBE};

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(3), .MC_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
        .PCSrcE(PCSrcE), .McOpE(McOpE), .McDoneE(McDoneE), .ClrCnt(ClrCnt),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .McTimeout(McTimeout), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    task automatic clear_inputs;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
        McOpE = 0; McDoneE = 0; ClrCnt = 0;
    endtask

    task automatic clear_counters;
        ClrCnt = 1'b1;
        @(posedge clk); #1;
        ClrCnt = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        ctlQ.push_back(C_NONE);
        #12;
        tests_run++;
        if (ctl !== ctlQ[0] || fwd !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: ctl=%b fwd=%b expected ctl=%b fwd=0000", ctl, fwd, ctlQ[0]);
        end
        void'(ctlQ.pop_front());
        tests_run++;
        if (StallCnt !== 4'd0 || FlushCnt !== 4'd0 || McTimeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_regs: StallCnt=%0d FlushCnt=%0d McTimeout=%b expected 0 0 0",
                     StallCnt, FlushCnt, McTimeout);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_forward;
        logic [3:0] exp;
        logic [4:0] r1 [4] = '{5'd5, 5'd5, 5'd0, 5'd0};
        logic [4:0] r2 [4] = '{5'd5, 5'd5, 5'd5, 5'd9};
        logic       wm [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] ex [4] = '{4'b1010, 4'b0101, 4'b0001, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            Rs1E = r1[i]; Rs2E = r2[i]; RegWriteM = wm[i]; RegWriteW = 1'b1;
            RdM = (i == 3) ? 5'd9 : 5'd5;
            RdW = 5'd5;
            fwdQ.push_back(ex[i]);
            #1;
            exp = fwdQ.pop_front();
            tests_run++;
            if (fwd !== exp) begin
                tests_failed++;
                $display("FAIL forward_%0d: {FwdA,FwdB}=%b expected %b", i, fwd, exp);
            end
        end
        clear_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_load_use;
        logic [5:0] exp;
        clear_counters();
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        for (int c = 1; c <= 5; c++) begin
            ctlQ.push_back((c <= 3) ? C_LD : C_NONE);
            @(negedge clk);
            exp = ctlQ.pop_front();
            tests_run++;
            if (ctl !== exp) begin
                tests_failed++;
                $display("FAIL load_use_cycle%0d: ctl=%b expected %b", c, ctl, exp);
            end
            @(posedge clk); #1;
            ResultSrcE0 = 1'b0; RdE = 5'd0;
        end
        tests_run++;
        if (StallCnt !== 4'd3) begin
            tests_failed++;
            $display("FAIL load_use_stallcnt: StallCnt=%0d expected 3", StallCnt);
        end
        clear_inputs();
    endtask

    task automatic test_load_branch;
        logic [5:0] exp;
        clear_counters();
        ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        ctlQ.push_back(C_NONE);
        @(negedge clk);
        exp = ctlQ.pop_front();
        tests_run++;
        if (ctl !== exp) begin
            tests_failed++;
            $display("FAIL load_x0: ctl=%b expected %b", ctl, exp);
        end
        @(posedge clk); #1;
        RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
        ctlQ.push_back(C_BR);
        @(negedge clk);
        exp = ctlQ.pop_front();
        tests_run++;
        if (ctl !== exp) begin
            tests_failed++;
            $display("FAIL load_branch: ctl=%b expected %b", ctl, exp);
        end
        @(posedge clk); #1;
        clear_inputs();
        ctlQ.push_back(C_NONE);
        @(negedge clk);
        exp = ctlQ.pop_front();
        tests_run++;
        if (ctl !== exp || FlushCnt !== 4'd1 || StallCnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL branch_after: ctl=%b FlushCnt=%0d StallCnt=%0d expected %b 1 0",
                     ctl, FlushCnt, StallCnt, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_multicycle;
        logic [5:0] exp;
        McOpE = 1'b1; McDoneE = 1'b1;
        ctlQ.push_back(C_NONE);
        @(negedge clk);
        exp = ctlQ.pop_front();
        tests_run++;
        if (ctl !== exp) begin
            tests_failed++;
            $display("FAIL mc_single_cycle: ctl=%b expected %b", ctl, exp);
        end
        @(posedge clk); #1;
        for (int c = 1; c <= 6; c++) begin
            McOpE = (c <= 5); McDoneE = (c == 5);
            ctlQ.push_back((c <= 4) ? C_MC : C_NONE);
            @(negedge clk);
            exp = ctlQ.pop_front();
            tests_run++;
            if (ctl !== exp) begin
                tests_failed++;
                $display("FAIL mc_cycle%0d: ctl=%b expected %b", c, ctl, exp);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (McTimeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL mc_no_timeout: McTimeout=%b expected 0", McTimeout);
        end
        clear_inputs();
    endtask

    task automatic test_watchdog;
        logic [5:0] exp;
        McOpE = 1'b1; McDoneE = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            ctlQ.push_back(C_MC);
            @(negedge clk);
            exp = ctlQ.pop_front();
            tests_run++;
            if (ctl !== exp || McTimeout !== (c > 8)) begin
                tests_failed++;
                $display("FAIL watchdog_cycle%0d: ctl=%b McTimeout=%b expected %b %b",
                         c, ctl, McTimeout, exp, (c > 8));
            end
            if (c < 12) begin
                @(posedge clk); #1;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (McTimeout !== 1'b0 || ctl !== C_NONE) begin
            tests_failed++;
            $display("FAIL watchdog_async_reset: McTimeout=%b ctl=%b expected 0 %b",
                     McTimeout, ctl, C_NONE);
        end
        clear_inputs();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation;
        logic [3:0] exp;
        clear_counters();
        McOpE = 1'b1; McDoneE = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        exp = 4'd15;
        tests_run++;
        if (StallCnt !== exp) begin
            tests_failed++;
            $display("FAIL stallcnt_saturate: StallCnt=%0d expected %0d", StallCnt, exp);
        end
        @(posedge clk); #1;
        ClrCnt = 1'b1;
        @(posedge clk); #1;
        ClrCnt = 1'b0;
        @(negedge clk);
        tests_run++;
        if (StallCnt !== 4'd0 || StallF !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_priority: StallCnt=%0d StallF=%b expected 0 1", StallCnt, StallF);
        end
        @(posedge clk); #1;
        McDoneE = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_load_branch();
        test_multicycle();
        test_watchdog();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
